// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one systolic_core: loads weights, waits for them to settle,
// latches them, streams activations and collects results downstream.
module systolic_seq_ctrl #(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int ROW_W      = 16,
   parameter int SETTLE_CYC = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_load_w,
   input  logic [ROW_W-1:0]        cmd_rows,
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [N*DATA_WIDTH-1:0] w_data,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [N*DATA_WIDTH-1:0] a_data,
   output logic                    r_valid,
   input  logic                    r_ready,
   output logic [N*ACC_WIDTH-1:0]  r_data,
   output logic                    r_last,
   output logic [N-1:0]            core_load_weight,
   output logic                    core_valid,
   input  logic                    core_ready,
   output logic [N*DATA_WIDTH-1:0] core_x,
   output logic [N*ACC_WIDTH-1:0]  core_y,
   output logic                    core_latch,
   input  logic [N*ACC_WIDTH-1:0]  core_y_out,
   input  logic                    core_valid_out,
   output logic                    core_ready_in,
   output logic                    busy,
   output logic                    done
);

   localparam int CW = $clog2(N + 1);
   localparam int SW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_SETTLE, S_LATCH, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [ROW_W-1:0] m_q, in_cnt, out_cnt;
   logic [CW-1:0]    w_cnt;
   logic [SW-1:0]    settle_cnt;
   logic             w_acc, a_acc, r_acc;

   // Partial sums always start from zero; results stream straight through.
   assign core_y = '0;
   assign r_data = core_y_out;
   assign w_acc  = w_valid && w_ready;
   assign a_acc  = a_valid && a_ready;
   assign r_acc  = r_valid && r_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and combinational handshake steering per state
   always_comb begin
      state_nxt        = state;
      cmd_ready        = 1'b0;
      w_ready          = 1'b0;
      a_ready          = 1'b0;
      core_valid       = 1'b0;
      core_x           = '0;
      core_load_weight = '0;
      core_latch       = 1'b0;
      r_valid          = 1'b0;
      r_last           = 1'b0;
      core_ready_in    = 1'b0;
      done             = 1'b0;
      busy             = (state != S_IDLE);
      // result collection runs alongside streaming and during drain
      if (state == S_STREAM || state == S_DRAIN) begin
         r_valid       = core_valid_out;
         core_ready_in = r_ready;
         r_last        = core_valid_out && (out_cnt == m_q - ROW_W'(1));
      end
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_load_w)           state_nxt = S_LOAD_W;
               else if (cmd_rows != '0)  state_nxt = S_STREAM;
               else                      state_nxt = S_DONE;
            end
         end
         S_LOAD_W: begin
            core_x           = w_data;
            core_load_weight = '1;
            core_valid       = w_valid;
            w_ready          = core_ready;
            if (w_valid && core_ready && w_cnt == CW'(N - 1)) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYC - 1)) state_nxt = S_LATCH;
         end
         S_LATCH: begin
            core_latch = 1'b1;
            state_nxt  = (m_q != '0) ? S_STREAM : S_DONE;
         end
         S_STREAM: begin
            core_x     = a_data;
            core_valid = a_valid;
            a_ready    = core_ready;
            if (a_valid && core_ready && in_cnt == m_q - ROW_W'(1)) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_cnt == m_q) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Job length capture and beat/cycle counters; in and out counts run concurrently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q        <= '0;
         w_cnt      <= '0;
         settle_cnt <= '0;
         in_cnt     <= '0;
         out_cnt    <= '0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            m_q        <= cmd_rows;
            w_cnt      <= '0;
            settle_cnt <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
         end
         if (w_acc)              w_cnt      <= w_cnt + CW'(1);
         if (state == S_SETTLE)  settle_cnt <= settle_cnt + SW'(1);
         if (a_acc)              in_cnt     <= in_cnt + ROW_W'(1);
         if (r_acc)              out_cnt    <= out_cnt + ROW_W'(1);
      end
   end

endmodule
